if_fetch_queue: RTL and testbench
=================================

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, sets instruction queue entries; legal values are powers of two from 2 to 16.
REQ-002 Parameter ADDR_W, default 13, sets the fetch address width, matching the PC output width.
REQ-003 Parameter DATA_W, default 32, sets the instruction word width.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 pc_in  input  ADDR_W  fetch address from the program counter.
REQ-007 pc_valid  input  1  pc_in is a valid fetch request.
REQ-008 pc_ready  output  1  the block accepts pc_in this cycle.
REQ-009 imem_req  output  1  instruction memory read request.
REQ-010 imem_addr  output  ADDR_W  instruction memory read address.
REQ-011 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-012 imem_rdata  input  DATA_W  instruction word from memory.
REQ-013 flush  input  1  discards all queued and in-flight fetches.
REQ-014 instr_valid  output  1  the queue head is valid.
REQ-015 instr_out  output  DATA_W  instruction at the queue head.
REQ-016 instr_pc  output  ADDR_W  fetch address of the queue head.
REQ-017 instr_ready  input  1  decode consumes the head this cycle.

Function
REQ-018 The FSM SHALL have three states: IDLE, WAIT_ACK and DROP; at most one memory request SHALL be outstanding.
REQ-019 pc_ready SHALL be 1 only when state is IDLE, count < DEPTH and flush is 0.
REQ-020 On pc_valid && pc_ready: latch pc_in into imem_addr, set imem_req = 1 and enter WAIT_ACK on the next cycle.
REQ-021 imem_req and imem_addr SHALL remain stable while waiting, until the cycle in which imem_ack = 1.
REQ-022 In WAIT_ACK with imem_ack = 1 and flush = 0: push {imem_addr, imem_rdata} to the queue tail, drop imem_req and return to IDLE next cycle.
REQ-023 Minimum issue-to-issue spacing SHALL be 2 cycles with zero-wait memory (accept, ack, accept again).
REQ-024 instr_valid SHALL equal (count != 0); instr_out and instr_pc SHALL be driven from the head entry.
REQ-025 Pop on instr_valid && instr_ready; simultaneous push and pop SHALL leave count unchanged.
REQ-026 A push SHALL never overflow, because slot availability is checked at issue; a pop with count = 0 SHALL be ignored.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.
REQ-028 On flush = 1, the next cycle SHALL have count = 0, pointers = 0 and instr_valid = 0; flush overrides a same-cycle pop and push.
REQ-029 Flush handling by state:
- flush in WAIT_ACK with imem_ack = 0: enter DROP.
- flush with imem_ack = 1: discard the data and enter IDLE.
- flush in IDLE: pc_valid is ignored that cycle.
REQ-030 DROP SHALL keep imem_req held until imem_ack, discard that data, then go to IDLE; pc_ready = 0 in DROP.

Reset
REQ-031 Reset SHALL force state IDLE, count 0, pointers 0, imem_req 0, imem_addr 0, instr_valid 0, instr_out 0, instr_pc 0.
REQ-032 Reset SHALL override flush and all handshakes; an in-flight request is abandoned and a later imem_ack in IDLE SHALL be ignored.

Configuration
REQ-033 When macro IFQ_PERF_CNT_EN is defined, the block SHALL add output perf_stall_cnt [15:0].
- The counter SHALL increment on each cycle with pc_valid && !pc_ready and saturate at 16'hFFFF.
- Reset SHALL clear it; flush SHALL NOT clear it.
REQ-034 Without IFQ_PERF_CNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-035 Zero-wait memory with pc_in = 0,1,2,3 held valid and instr_ready = 1 -> instr_pc sequence 0,1,2,3 with matching instr_out, one issue every 2 cycles.
REQ-036 instr_ready = 0 with 4 fetches (DEPTH = 4) -> count = 4, pc_ready = 0; one pop -> pc_ready = 1 the next cycle.
REQ-037 Memory acks 3 cycles late -> imem_addr and imem_req stable for all 3 cycles; the entry appears the cycle after ack.
REQ-038 Flush in WAIT_ACK, ack 2 cycles later -> DROP, data discarded, instr_valid = 0, pc_ready = 1 the cycle after ack.
REQ-039 Reset asserted with 2 queued entries and a request in flight -> all outputs 0 next cycle; a late imem_ack creates no entry.
REQ-040 With IFQ_PERF_CNT_EN: queue full for 10 cycles with pc_valid = 1 -> perf_stall_cnt = 10; flush leaves it at 10.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: issues one memory read at a time and buffers returned words.
// Optional stall counter port perf_stall_cnt is enabled by defining IFQ_PERF_CNT_EN.
module if_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              pc_valid,
    output logic              pc_ready,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              flush,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
`ifdef IFQ_PERF_CNT_EN
    ,
    output logic [15:0]       perf_stall_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        DROP     = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              imem_req_reg;
    logic [ADDR_W-1:0] imem_addr_reg;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic accept;
    logic push;
    logic pop;
    logic req_done;

    assign pc_ready    = (state_reg == IDLE) && (count_reg < CNT_W'(DEPTH)) && !flush;
    assign instr_valid = (count_reg != '0);
    assign pop         = instr_valid && instr_ready && !flush;
    assign imem_req    = imem_req_reg;
    assign imem_addr   = imem_addr_reg;

    // Head is gated so an empty or freshly reset queue presents zeros.
    assign instr_out = instr_valid ? data_mem[rd_ptr_reg] : '0;
    assign instr_pc  = instr_valid ? pc_mem[rd_ptr_reg]   : '0;

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        push       = 1'b0;
        req_done   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pc_valid && pc_ready) begin
                    accept     = 1'b1;
                    state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (imem_ack) begin
                    req_done   = 1'b1;
                    push       = !flush;
                    state_next = IDLE;
                end else if (flush) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    req_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            imem_req_reg  <= 1'b0;
            imem_addr_reg <= '0;
        end else if (accept) begin
            imem_req_reg  <= 1'b1;
            imem_addr_reg <= pc_in;
        end else if (req_done) begin
            imem_req_reg  <= 1'b0;
        end
    end

    // Occupancy is checked at issue, so a push never finds the queue full.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_reg]   <= imem_addr_reg;
            data_mem[wr_ptr_reg] <= imem_rdata;
        end
    end

`ifdef IFQ_PERF_CNT_EN
    logic [15:0] perf_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cnt_reg <= '0;
        end else if (pc_valid && !pc_ready && (perf_cnt_reg != 16'hFFFF)) begin
            perf_cnt_reg <= perf_cnt_reg + 16'd1;
        end
    end

    assign perf_stall_cnt = perf_cnt_reg;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized scoreboard bench for if_fetch_queue against a queue-based reference model.
module tb_if_fetch_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] pc_in = '0;
    logic              pc_valid = 1'b0;
    logic              pc_ready;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack = 1'b0;
    logic [DATA_W-1:0] imem_rdata = '0;
    logic              flush = 1'b0;
    logic              instr_valid;
    logic [DATA_W-1:0] instr_out;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready = 1'b0;
`ifdef IFQ_PERF_CNT_EN
    logic [15:0]       perf_stall_cnt;
`endif

    if_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .pc_valid    (pc_valid),
        .pc_ready    (pc_ready),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .flush       (flush),
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
`ifdef IFQ_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            exp_q[$];
    logic              m_busy = 1'b0;
    logic              m_drop = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    int                m_perf = 0;
    int                n_cmp = 0;
    int                n_err = 0;
    int                max_lat = 0;
    int                p_spur = 0;

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return (DATA_W'(a) * 32'h9E3779B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
        end
    endtask

    // Memory model: random latency per request, correct data only on ack.
    int lat_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (imem_req) begin
            if (lat_cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                lat_cnt--;
            end
        end else begin
            imem_ack   = ($urandom_range(0, 99) < p_spur);
            imem_rdata = $urandom;
            lat_cnt    = $urandom_range(0, max_lat);
        end
    end

    // Monitor compares the visible outputs, then advances the model for the coming edge.
    always @(negedge clk) begin
        logic exp_ready;
        entry_t hd;
        exp_ready = !m_busy && (exp_q.size() < DEPTH) && !flush;
        check("pc_ready", 32'(pc_ready), 32'(exp_ready));
        check("imem_req", 32'(imem_req), 32'(m_busy));
        check("imem_addr", 32'(imem_addr), 32'(m_addr));
        check("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            hd = exp_q[0];
            check("instr_pc", 32'(instr_pc), 32'(hd.pc));
            check("instr_out", instr_out, hd.data);
            if (instr_ready && !flush && !reset)
                $display("pop pc=%h data=%h", instr_pc, instr_out);
        end else begin
            check("instr_pc_empty", 32'(instr_pc), 32'd0);
            check("instr_out_empty", instr_out, 32'd0);
        end
`ifdef IFQ_PERF_CNT_EN
        check("perf_stall_cnt", 32'(perf_stall_cnt), 32'(m_perf));
`endif
        if (reset) begin
            exp_q.delete();
            m_busy = 1'b0;
            m_drop = 1'b0;
            m_addr = '0;
            m_perf = 0;
        end else begin
            if (pc_valid && !exp_ready && m_perf < 16'hFFFF) m_perf++;
            if (flush) begin
                exp_q.delete();
                if (m_busy && imem_ack) begin
                    m_busy = 1'b0;
                    m_drop = 1'b0;
                end else if (m_busy) begin
                    m_drop = 1'b1;
                end
            end else begin
                if (exp_q.size() != 0 && instr_ready) void'(exp_q.pop_front());
                if (m_busy && imem_ack) begin
                    if (!m_drop) exp_q.push_back('{pc: m_addr, data: mem_word(m_addr)});
                    m_busy = 1'b0;
                    m_drop = 1'b0;
                end else if (!m_busy && pc_valid && exp_ready) begin
                    m_busy = 1'b1;
                    m_addr = pc_in;
                end
            end
        end
    end

    // Phase table: valid%, ready%, flush%, reset%, max latency, spurious ack%, sequential pc
    int ph[7][7] = '{
        '{100, 100,  0, 0, 0,  0, 1},
        '{100,   0,  0, 0, 0,  0, 1},
        '{ 90,  10,  0, 0, 3,  0, 0},
        '{ 80,  60,  6, 0, 4,  0, 0},
        '{100,  30, 10, 3, 2, 20, 0},
        '{ 70,  80,  3, 1, 6, 10, 0},
        '{100,   0,  0, 0, 0,  0, 1}
    };

    initial begin
        int seq_pc;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        seq_pc = 0;
        for (int p = 0; p < 7; p++) begin
            max_lat = ph[p][4];
            p_spur  = ph[p][5];
            for (int c = 0; c < 300; c++) begin
                @(posedge clk);
                #1;
                pc_valid    = ($urandom_range(0, 99) < ph[p][0]);
                instr_ready = ($urandom_range(0, 99) < ph[p][1]);
                flush       = ($urandom_range(0, 99) < ph[p][2]);
                reset       = ($urandom_range(0, 99) < ph[p][3]);
                if (ph[p][6] != 0) begin
                    if (pc_valid && pc_ready) seq_pc++;
                    pc_in = ADDR_W'(seq_pc);
                end else begin
                    pc_in = ADDR_W'($urandom);
                end
            end
            @(posedge clk);
            #1;
            flush = 1'b1;
            pc_valid = 1'b0;
            reset = (p == 3);
            $display("phase %0d done compared=%0d", p, n_cmp);
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
